// File: rtl/uart_rx_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_param                                                            |
// | Oversampled RS-232 receiver with configurable data width, parity and     |
// | stop bits. The break_o output exists only if UART_RX_BREAK_DET_EN is set.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic                 en_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
`ifdef UART_RX_BREAK_DET_EN
    output logic                 break_o,
`endif
    output logic                 busy_o
);

    localparam int c_DIV_RAW = CLK_FREQ / (BAUD * OVS);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_DIV_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OVS_W   = $clog2(OVS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_OVS_W-1:0] c_OVS_LAST = c_OVS_W'(OVS - 1);
    localparam logic [c_OVS_W-1:0] c_SMP0     = c_OVS_W'(OVS / 2 - 1);
    localparam logic [c_OVS_W-1:0] c_SMP1     = c_OVS_W'(OVS / 2);
    localparam logic [c_OVS_W-1:0] c_SMP2     = c_OVS_W'(OVS / 2 + 1);
    localparam logic [3:0]         c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_LAST_STOP = 4'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [1:0]           r_sync;
    logic                 w_rx_s;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic                 w_tick;
    logic [c_OVS_W-1:0]   r_ovs_cnt;
    logic                 w_mid;
    logic                 w_bit_end;
    logic                 r_s0;
    logic                 r_s1;
    logic                 w_vote;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_ferr_acc;
    logic                 r_armed;
    logic                 w_par_err;
    logic                 w_report;

    assign w_rx_s    = r_sync[1];
    assign w_tick    = (r_div_cnt == c_DIV_LAST);
    assign w_mid     = w_tick && (r_ovs_cnt == c_SMP2);
    assign w_bit_end = w_tick && (r_ovs_cnt == c_OVS_LAST);
    assign w_vote    = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    assign w_par_err = (PARITY == 1) ? ((^r_shift) ^ r_par_bit)
                     : (PARITY == 2) ? ~((^r_shift) ^ r_par_bit)
                     : 1'b0;
    assign w_report  = (r_state == c_ST_DONE) && en_i;
    assign busy_o    = (r_state != c_ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (en_i && r_armed && !w_rx_s) w_state_next = c_ST_START;
            end
            c_ST_START: begin
                if (w_mid && w_vote)  w_state_next = c_ST_IDLE;
                else if (w_bit_end)   w_state_next = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_bit_end && (r_bit_cnt == c_LAST_DATA))
                    w_state_next = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: begin
                if (w_bit_end) w_state_next = c_ST_STOP;
            end
            c_ST_STOP: begin
                // Finish at the last mid-sample so a following start edge is caught.
                if (w_mid && (r_bit_cnt == c_LAST_STOP)) w_state_next = c_ST_DONE;
            end
            c_ST_DONE:  w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
        if (!en_i) w_state_next = c_ST_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_sync    <= 2'b11;
            r_div_cnt <= '0;
            r_ovs_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], rx_i};
            if ((r_state == c_ST_IDLE) || w_tick) r_div_cnt <= '0;
            else                                  r_div_cnt <= r_div_cnt + 1'b1;
            if (r_state == c_ST_IDLE)             r_ovs_cnt <= '0;
            else if (w_bit_end)                   r_ovs_cnt <= '0;
            else if (w_tick)                      r_ovs_cnt <= r_ovs_cnt + 1'b1;
            if (w_state_next != r_state)          r_bit_cnt <= '0;
            else if (w_bit_end)                   r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_s0         <= 1'b0;
            r_s1         <= 1'b0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_ferr_acc   <= 1'b0;
            r_armed      <= 1'b0;
            data_o       <= '0;
            valid_o      <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (w_tick && (r_ovs_cnt == c_SMP0)) r_s0 <= w_rx_s;
            if (w_tick && (r_ovs_cnt == c_SMP1)) r_s1 <= w_rx_s;
            if (r_state == c_ST_IDLE) r_ferr_acc <= 1'b0;
            if ((r_state == c_ST_DATA) && w_mid)   r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
            if ((r_state == c_ST_PARITY) && w_mid) r_par_bit <= w_vote;
            if ((r_state == c_ST_STOP) && w_mid && !w_vote) r_ferr_acc <= 1'b1;
            // A low line after a frame or abort must go high before a new start is accepted.
            if ((r_state == c_ST_IDLE) && w_rx_s)
                r_armed <= 1'b1;
            else if ((r_state == c_ST_DONE) || ((r_state != c_ST_IDLE) && !en_i))
                r_armed <= 1'b0;
            if (w_report) begin
                valid_o      <= 1'b1;
                data_o       <= r_shift;
                parity_err_o <= w_par_err;
                frame_err_o  <= r_ferr_acc;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic r_break;
    assign break_o = r_break;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_break <= 1'b0;
        end else if (w_report && (r_shift == '0) && r_ferr_acc &&
                     ((PARITY == 0) || !r_par_bit)) begin
            r_break <= 1'b1;
        end else if (w_rx_s) begin
            r_break <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// Scoreboard bench for uart_rx_param: 8N1, 7E1 and 8N2 instances at 16 clk/bit.
module tb_uart_rx_param;

    localparam int c_BIT = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [2:0] rx = 3'b111;

    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic       valid_a, perr_a, ferr_a, busy_a;
    logic       valid_b, perr_b, ferr_b, busy_b;
    logic       valid_c, perr_c, ferr_c, busy_c;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk_a, brk_b, brk_c;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVS(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .rx_i(rx[0]), .en_i(en),
        .data_o(data_a), .valid_o(valid_a), .parity_err_o(perr_a),
        .frame_err_o(ferr_a),
`ifdef UART_RX_BREAK_DET_EN
        .break_o(brk_a),
`endif
        .busy_o(busy_a));

    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVS(16),
                    .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .rx_i(rx[1]), .en_i(en),
        .data_o(data_b), .valid_o(valid_b), .parity_err_o(perr_b),
        .frame_err_o(ferr_b),
`ifdef UART_RX_BREAK_DET_EN
        .break_o(brk_b),
`endif
        .busy_o(busy_b));

    uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVS(16),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk_i(clk), .rst_i(rst_n), .rx_i(rx[2]), .en_i(en),
        .data_o(data_c), .valid_o(valid_c), .parity_err_o(perr_c),
        .frame_err_o(ferr_c),
`ifdef UART_RX_BREAK_DET_EN
        .break_o(brk_c),
`endif
        .busy_o(busy_c));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic expect_frame(input int which, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.data = d;
        e.perr = pe;
        e.ferr = fe;
        if (which == 0)      q_a.push_back(e);
        else if (which == 1) q_b.push_back(e);
        else                 q_c.push_back(e);
    endtask

    task automatic check_pop(input int which, input logic [8:0] d, input logic pe, input logic fe);
        exp_t  e;
        int    sz;
        string nm;
        nm = (which == 0) ? "a" : (which == 1) ? "b" : "c";
        sz = (which == 0) ? q_a.size() : (which == 1) ? q_b.size() : q_c.size();
        check({"valid_expected_", nm}, 32'(sz != 0), 32'd1);
        if (sz != 0) begin
            if (which == 0)      e = q_a.pop_front();
            else if (which == 1) e = q_b.pop_front();
            else                 e = q_c.pop_front();
            check({"data_", nm}, 32'(d), 32'(e.data));
            check({"parity_err_", nm}, 32'(pe), 32'(e.perr));
            check({"frame_err_", nm}, 32'(fe), 32'(e.ferr));
        end
    endtask

    // Monitor: every valid pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (valid_a) check_pop(0, {1'b0, data_a}, perr_a, ferr_a);
        if (valid_b) check_pop(1, {2'b0, data_b}, perr_b, ferr_b);
        if (valid_c) check_pop(2, {1'b0, data_c}, perr_c, ferr_c);
    end

    task automatic drive_bit(input int which, input logic b, input int cycles);
        rx[which] = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                              input int par, input int nstop, input logic last_stop);
        drive_bit(which, 1'b0, c_BIT);
        for (int i = 0; i < nbits; i++) drive_bit(which, d[i], c_BIT);
        if (par >= 0) drive_bit(which, par[0], c_BIT);
        for (int i = 0; i < nstop; i++)
            drive_bit(which, (i == nstop - 1) ? last_stop : 1'b1, c_BIT);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_busy;
        int   waited;

        idle(3);
        check("rst_data_a",  32'(data_a),  32'h0);
        check("rst_valid_a", 32'(valid_a), 32'h0);
        check("rst_perr_a",  32'(perr_a),  32'h0);
        check("rst_ferr_a",  32'(ferr_a),  32'h0);
        check("rst_busy_a",  32'(busy_a),  32'h0);
        check("rst_busy_b",  32'(busy_b),  32'h0);
        check("rst_busy_c",  32'(busy_c),  32'h0);
        rst_n = 1'b1;
        idle(5);

        // 8N1 single frame
        expect_frame(0, 9'h0A5, 1'b0, 1'b0);
        send_frame(0, 9'h0A5, 8, -1, 1, 1'b1);
        idle(4);
        check("busy_a_after_8n1", 32'(busy_a), 32'h0);
        check("data_a_held", 32'(data_a), 32'hA5);

        // 7E1: 0x55 has four ones, so correct even parity bit is 0
        expect_frame(1, 9'h055, 1'b0, 1'b0);
        send_frame(1, 9'h055, 7, 0, 1, 1'b1);
        expect_frame(1, 9'h055, 1'b1, 1'b0);
        send_frame(1, 9'h055, 7, 1, 1, 1'b1);
        idle(20);

        // 8N2 with second stop bit low, line held low afterwards
        expect_frame(2, 9'h03C, 1'b0, 1'b1);
        send_frame(2, 9'h03C, 8, -1, 2, 1'b0);
        saw_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_c) saw_busy = 1'b1;
        end
        check("no_restart_while_low_c", 32'(saw_busy), 32'h0);
        rx[2] = 1'b1;
        idle(20);
        expect_frame(2, 9'h03C, 1'b0, 1'b0);
        send_frame(2, 9'h03C, 8, -1, 2, 1'b1);
        idle(20);

        // Glitch: 4 clocks low is rejected by the start-bit vote
        drive_bit(0, 1'b0, 4);
        rx[0] = 1'b1;
        waited = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!busy_a) break;
            waited++;
        end
        check("glitch_busy_a_cleared", 32'(busy_a), 32'h0);
        idle(30);

        // Back-to-back frames
        expect_frame(0, 9'h000, 1'b0, 1'b0);
        expect_frame(0, 9'h0FF, 1'b0, 1'b0);
        expect_frame(0, 9'h081, 1'b0, 1'b0);
        send_frame(0, 9'h000, 8, -1, 1, 1'b1);
        send_frame(0, 9'h0FF, 8, -1, 1, 1'b1);
        send_frame(0, 9'h081, 8, -1, 1, 1'b1);
        idle(20);

        // Abort: en_i dropped mid bit 3 of 0x42 (bits 0..3 = 0,1,0,0)
        drive_bit(0, 1'b0, c_BIT);
        drive_bit(0, 1'b0, c_BIT);
        drive_bit(0, 1'b1, c_BIT);
        drive_bit(0, 1'b0, c_BIT);
        drive_bit(0, 1'b0, 8);
        en = 1'b0;
        idle(2);
        check("abort_busy_a", 32'(busy_a), 32'h0);
        rx[0] = 1'b1;
        idle(4);
        check("abort_data_a_held", 32'(data_a), 32'h81);
        en = 1'b1;
        idle(10);

        // Reset mid-frame
        drive_bit(0, 1'b0, c_BIT);
        drive_bit(0, 1'b0, c_BIT);
        drive_bit(0, 1'b1, 8);
        rst_n = 1'b0;
        rx[0] = 1'b1;
        idle(1);
        check("midrst_data_a",  32'(data_a),  32'h0);
        check("midrst_valid_a", 32'(valid_a), 32'h0);
        check("midrst_perr_a",  32'(perr_a),  32'h0);
        check("midrst_ferr_a",  32'(ferr_a),  32'h0);
        check("midrst_busy_a",  32'(busy_a),  32'h0);
        rst_n = 1'b1;
        idle(10);
        expect_frame(0, 9'h042, 1'b0, 1'b0);
        send_frame(0, 9'h042, 8, -1, 1, 1'b1);
        idle(20);
        check("final_data_a", 32'(data_a), 32'h42);

        check("queue_a_drained", 32'(q_a.size()), 32'h0);
        check("queue_b_drained", 32'(q_b.size()), 32'h0);
        check("queue_c_drained", 32'(q_c.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
